// File: rtl/html_char_streamer_pkg.sv
// Shared constants, state encoding and the whitespace-normalising helper for the streamer.
package html_char_streamer_pkg;

  localparam int CHAR_BITES = 8;

  localparam logic [CHAR_BITES-1:0] CHAR_NUL   = 8'h00;
  localparam logic [CHAR_BITES-1:0] CHAR_SPACE = 8'h20;
  localparam logic [CHAR_BITES-1:0] CHAR_TAB   = 8'h09;
  localparam logic [CHAR_BITES-1:0] CHAR_LF    = 8'h0A;
  localparam logic [CHAR_BITES-1:0] CHAR_CR    = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } stream_state_e;

  // CR, LF and TAB all read as a plain space to the parser.
  function automatic logic [CHAR_BITES-1:0] norm_ws(input logic [CHAR_BITES-1:0] c);
    return (c == CHAR_CR || c == CHAR_LF || c == CHAR_TAB) ? CHAR_SPACE : c;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO with occupancy count; read data is the current head (show-ahead).
module char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wptr_q, rptr_q;
  logic [CW-1:0]               count_q;

  // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wptr_q] <= wr_data_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (rd_en_i) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(wr_en_i) - CW'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));

  // The streamer only pops when it sees a non-empty FIFO.
  a_no_rd_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(rd_en_i && empty_o));

endmodule

// File: rtl/html_char_streamer.sv
// Fetches document bytes from a 1-cycle ROM, normalises whitespace, and presents one
// character at a time to html_parser, honouring its pause.
module html_char_streamer
  import html_char_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DOC_LENGTH = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  pause_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_rd_o,
  input  logic [CHAR_BITES-1:0] rom_data_i,
  output logic [CHAR_BITES-1:0] char_o,
  output logic                  char_valid_o,
  output logic                  state_enable_o,
  output logic                  done_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DOC_LENGTH - 1);

  stream_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q;
  logic                  fetch_end_q, fetch_end_d;
  logic                  last_space_q, last_space_d;
  logic [CHAR_BITES-1:0] char_q, char_d;
  logic                  char_valid_q, char_valid_d;

  logic                  fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [CHAR_BITES-1:0] fifo_rdata;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credits_used;
  logic                  ret_term, fetch_done, consume;
  logic [CHAR_BITES-1:0] ret_char;

  char_fifo #(.WIDTH(CHAR_BITES), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .wr_en_i   (fifo_wr),
    .wr_data_i (ret_char),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  // Returning byte: NUL ends the document, other bytes are normalised and
  // a space is dropped when the previous accepted char was already a space.
  assign ret_term = inflight_q && (rom_data_i == CHAR_NUL);
  assign ret_char = norm_ws(rom_data_i);
  assign fifo_wr  = inflight_q && !ret_term && !(ret_char == CHAR_SPACE && last_space_q);

  // Credit: never have more reads outstanding than free FIFO slots. The read is
  // also held off in the cycle a NUL comes back so nothing is fetched past it.
  assign credits_used = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign rom_rd_o     = (state_q == S_FILL || state_q == S_RUN) && !fetch_end_q && !ret_term
                        && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign rom_addr_o   = addr_q;
  assign fetch_done   = fetch_end_q && !inflight_q;

  // Output register handshake: pause only matters once the parser is enabled.
  assign consume = char_valid_q && !pause_i && (state_q == S_RUN || state_q == S_DRAIN);
  assign fifo_rd = (state_q == S_FILL || state_q == S_RUN || state_q == S_DRAIN)
                   && (!char_valid_q || consume) && !fifo_empty;

  // Next-state logic for the FSM, fetch address and output register.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fetch_end_d  = fetch_end_q | (rom_rd_o && addr_q == LAST_ADDR) | ret_term;
    last_space_d = fifo_wr ? (ret_char == CHAR_SPACE) : last_space_q;
    char_d       = char_q;
    char_valid_d = char_valid_q;
    // The counter parks on the last address instead of wrapping.
    if (rom_rd_o && addr_q != LAST_ADDR) addr_d = addr_q + ADDR_WIDTH'(1);
    if (fifo_rd) begin
      char_d       = fifo_rdata;
      char_valid_d = 1'b1;
    end else if (consume) begin
      char_valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE, S_DONE: if (start_i) begin
        state_d      = S_FILL;
        addr_d       = '0;
        fetch_end_d  = 1'b0;
        last_space_d = 1'b0;
      end
      S_FILL: begin
        if (fifo_rd) state_d = S_RUN;
        else if (fetch_done && fifo_empty) state_d = S_DONE;
      end
      S_RUN:   if (fetch_done) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty && (!char_valid_q || consume)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any read still in flight.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      fetch_end_q  <= 1'b0;
      last_space_q <= 1'b0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inflight_q   <= rom_rd_o;
      fetch_end_q  <= fetch_end_d;
      last_space_q <= last_space_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
    end
  end

  assign char_o         = char_q;
  assign char_valid_o   = char_valid_q;
  assign state_enable_o = (state_q == S_RUN || state_q == S_DRAIN);
  assign done_o         = (state_q == S_DONE);

  // Credit-based fetch means a push into a full FIFO always pairs with a pop.
  a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
                                  !(fifo_wr && fifo_full && !fifo_rd));

endmodule

// File: tb/tb_html_char_streamer.sv
module tb_html_char_streamer;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    string rom_s;
    string exp_s;
    bit    gapless;
  } vec_t;

  logic clock, reset, start, start_b, pause;
  logic [7:0] rom_addr_a, rom_data_a, ch_a;
  logic       rom_rd_a, cv_a, se_a, done_a;
  logic [3:0] rom_addr_b;
  logic [7:0] rom_data_b, ch_b;
  logic       rom_rd_b, cv_b, se_b, done_b;

  logic [7:0] rom_a [0:255];
  logic [7:0] rom_b [0:15];

  int   n_chk, n_pass;
  bit   cap_en, capb_en, seen_valid, seen_se;
  int   gaps, exp_len, rd_b, max_addr_b;
  bq_t  got_a, got_b;

  html_char_streamer #(.ADDR_WIDTH(8), .DOC_LENGTH(256), .FIFO_DEPTH(4)) u_dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .pause_i(pause),
    .rom_addr_o(rom_addr_a), .rom_rd_o(rom_rd_a), .rom_data_i(rom_data_a),
    .char_o(ch_a), .char_valid_o(cv_a), .state_enable_o(se_a), .done_o(done_a));

  html_char_streamer #(.ADDR_WIDTH(4), .DOC_LENGTH(8), .FIFO_DEPTH(4)) u_dut8 (
    .clock_i(clock), .reset_i(reset), .start_i(start_b), .pause_i(pause),
    .rom_addr_o(rom_addr_b), .rom_rd_o(rom_rd_b), .rom_data_i(rom_data_b),
    .char_o(ch_b), .char_valid_o(cv_b), .state_enable_o(se_b), .done_o(done_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read ROMs
  always @(posedge clock) begin
    if (rom_rd_a) rom_data_a <= rom_a[rom_addr_a];
    if (rom_rd_b) rom_data_b <= rom_b[rom_addr_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_seq(input string nm, input bq_t got, input bq_t exp);
    int bad;
    bad = -1;
    n_chk++;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    if (bad < 0 && got.size() != exp.size()) bad = (got.size() < exp.size()) ? got.size() : exp.size();
    if (bad < 0) n_pass++;
    else $display("FAIL %s: got %0d chars, expected %0d chars, first difference at index %0d",
                  nm, got.size(), exp.size(), bad);
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: walk the document, stop at NUL or the length limit, map CR/LF/TAB
  // to space, and keep at most one space in a row.
  function automatic bq_t ref_stream(input bq_t img, input int doc_len);
    bq_t o;
    bit  last_sp;
    logic [7:0] c;
    last_sp = 1'b0;
    for (int a = 0; a < doc_len && a < img.size(); a++) begin
      c = img[a];
      if (c == 8'h00) break;
      if (c == 8'h09 || c == 8'h0A || c == 8'h0D) c = 8'h20;
      if (!(c == 8'h20 && last_sp)) begin
        o.push_back(c);
        last_sp = (c == 8'h20);
      end
    end
    return o;
  endfunction

  task automatic load_a(input bq_t img);
    for (int i = 0; i < 256; i++) rom_a[i] = 8'h00;
    for (int i = 0; i < img.size() && i < 256; i++) rom_a[i] = img[i];
  endtask

  // Output monitor: records consumed chars and checks that a paused char holds.
  initial begin
    bit hold_prev;
    logic [7:0] hold_ch;
    hold_prev = 1'b0;
    hold_ch = '0;
    forever begin
      @(negedge clock);
      if (cap_en) begin
        if (se_a && !cv_a && got_a.size() < exp_len) gaps++;
        if (hold_prev) chk("pause_hold", {cv_a, ch_a}, {1'b1, hold_ch});
        hold_prev = cv_a && pause;
        hold_ch = ch_a;
        if (cv_a) seen_valid = 1'b1;
        if (se_a) seen_se = 1'b1;
        if (cv_a && !pause) got_a.push_back(ch_a);
      end else begin
        hold_prev = 1'b0;
      end
      if (capb_en) begin
        if (cv_b && !pause) got_b.push_back(ch_b);
        if (rom_rd_b) begin
          rd_b++;
          if (int'(rom_addr_b) > max_addr_b) max_addr_b = int'(rom_addr_b);
        end
      end
    end
  end

  task automatic run_doc(input bq_t img, input bit rnd);
    bq_t e;
    load_a(img);
    e = ref_stream(img, 256);
    exp_len = e.size();
    got_a.delete();
    gaps = 0;
    seen_valid = 1'b0;
    seen_se = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    cap_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 400 && !done_a; k++) begin
      pause = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(posedge clock); #1;
    end
    pause = 1'b0;
    chk("done_reached", done_a, 1);
    cap_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    bq_t  img, e;
    int   bad_hold, rd_late, r, len;

    vt[0] = '{"<p>ab</p>", "<p>ab</p>", 1'b1};
    vt[1] = '{"a\r\n\t  b", "a b", 1'b0};
    vt[2] = '{"", "", 1'b1};
    vt[3] = '{"  x\t\ty ", " x y ", 1'b0};
    vt[4] = '{"A\nB\rC", "A B C", 1'b1};

    n_chk = 0; n_pass = 0;
    cap_en = 0; capb_en = 0; gaps = 0; exp_len = 0; rd_b = 0; max_addr_b = 0;
    start = 0; start_b = 0; pause = 0; reset = 0;
    for (int i = 0; i < 16; i++) rom_b[i] = 8'h61 + 8'(i);

    // Reset state
    #2 reset = 1'b1;
    #3;
    chk("reset_outputs_a", {rom_addr_a, rom_rd_a, ch_a, cv_a, se_a, done_a}, 0);
    chk("reset_outputs_b", {rom_addr_b, rom_rd_b, ch_b, cv_b, se_b, done_b}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Directed document table
    for (int i = 0; i < 5; i++) begin
      img = s2q(vt[i].rom_s);
      img.push_back(8'h00);
      e = s2q(vt[i].exp_s);
      run_doc(img, 1'b0);
      chk_seq($sformatf("vec%0d_stream", i), got_a, e);
      chk($sformatf("vec%0d_state_enable_end", i), se_a, 0);
      chk($sformatf("vec%0d_valid_seen", i), seen_valid, (e.size() > 0));
      chk($sformatf("vec%0d_enable_seen", i), seen_se, (e.size() > 0));
      if (vt[i].gapless) chk($sformatf("vec%0d_gaps", i), gaps, 0);
    end

    // Long pause on the first char: char holds, fetching stops once the FIFO is full
    img = s2q("xyzw0123456789");
    img.push_back(8'h00);
    load_a(img);
    e = ref_stream(img, 256);
    exp_len = e.size();
    got_a.delete();
    gaps = 0;
    pause = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    cap_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && !cv_a; k++) @(negedge clock);
    chk("pause_first_valid", cv_a, 1);
    bad_hold = 0;
    rd_late = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!(cv_a && ch_a == 8'h78)) bad_hold++;
      if (k >= 6 && rom_rd_a) rd_late++;
    end
    chk("pause_x_held", bad_hold, 0);
    chk("pause_no_rd_when_full", rd_late, 0);
    @(posedge clock); #1;
    pause = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("pause_release_next", {cv_a, ch_a}, {1'b1, 8'h79});
    for (int k = 0; k < 100 && !done_a; k++) @(negedge clock);
    chk("pause_done", done_a, 1);
    chk_seq("pause_stream", got_a, e);
    cap_en = 1'b0;

    // Document limited by DOC_LENGTH=8 (no NUL in ROM)
    img.delete();
    for (int i = 0; i < 16; i++) begin
      rom_b[i] = 8'(8'h61 + $urandom_range(0, 25));
      img.push_back(rom_b[i]);
    end
    e = ref_stream(img, 8);
    got_b.delete();
    rd_b = 0;
    max_addr_b = 0;
    @(posedge clock); #1;
    start_b = 1'b1;
    capb_en = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    for (int k = 0; k < 60 && !done_b; k++) begin
      @(posedge clock); #1;
    end
    chk("len8_done", done_b, 1);
    chk_seq("len8_stream", got_b, e);
    chk("len8_max_addr", max_addr_b, 7);
    chk("len8_reads", rd_b, 8);
    chk("len8_state_enable_end", se_b, 0);
    capb_en = 1'b0;

    // Reset mid-stream, then restart from address 0
    img.delete();
    for (int i = 0; i < 30; i++) img.push_back(8'(8'h41 + $urandom_range(0, 25)));
    img.push_back(8'h00);
    load_a(img);
    e = ref_stream(img, 256);
    exp_len = e.size();
    got_a.delete();
    @(posedge clock); #1;
    start = 1'b1;
    cap_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 40 && got_a.size() < 3; k++) @(negedge clock);
    chk("midreset_three_chars", (got_a.size() >= 3), 1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_outputs", {rom_addr_a, rom_rd_a, ch_a, cv_a, se_a, done_a}, 0);
    cap_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    run_doc(img, 1'b0);
    chk_seq("midreset_restart_stream", got_a, e);
    chk("midreset_first_char", (got_a.size() > 0) ? got_a[0] : 8'h00, img[0]);

    // Randomized documents with random pause
    for (int t = 0; t < 25; t++) begin
      img.delete();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 19);
        case (r)
          0:       img.push_back(8'h00);
          1, 2, 3: img.push_back(8'h20);
          4:       img.push_back(8'h09);
          5:       img.push_back(8'h0A);
          6:       img.push_back(8'h0D);
          default: img.push_back(8'(8'h61 + r));
        endcase
      end
      img.push_back(8'h00);
      e = ref_stream(img, 256);
      run_doc(img, 1'b1);
      chk_seq($sformatf("rand%0d_stream", t), got_a, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
